// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and state type for the TDM scan controller
package tdm_pkg;
    localparam int N_CH    = 4;
    localparam int SEL_W   = 2;
    localparam int DWELL_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - dwell and slot counters pacing the channel scan
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    output logic [SEL_W-1:0] slot,
    output logic             slot_end,
    output logic             frame_end
);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] dwell;

    assign slot_end  = run && (dwell == DWELL_LAST);
    assign frame_end = slot_end && (slot == SEL_W'(N_CH - 1));

    // Slot wraps 3->0 purely by overflow, which only happens on frame end.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            dwell <= '0;
            slot  <= '0;
        end else if (run) begin
            if (slot_end) begin
                dwell <= '0;
                slot  <= slot + 1'b1;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end
endmodule

// File: rtl/tdm_scan_ctrl.sv
// rtl/tdm_scan_ctrl.sv - 4-channel TDM scan controller; TDM_SCAN_FRAME_CNT_EN adds frame_cnt
module tdm_scan_ctrl
    import tdm_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_CH-1:0]  d_in,
    input  logic             line_in,
    output logic [N_CH-1:0]  d_hold,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  q,
    output logic             frame_valid,
    output logic             busy
`ifdef TDM_SCAN_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_cnt
`endif
);
    state_t           state, state_nxt;
    logic             load;
    logic             clr;
    logic             run;
    logic [SEL_W-1:0] slot;
    logic             slot_end;
    logic             frame_end;
    logic [N_CH-1:0]  shreg;
    logic [N_CH-1:0]  assembled;

    tdm_slot_counter #(.DWELL(DWELL)) u_slot_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .run       (run),
        .slot      (slot),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Counters are held clear whenever not actively scanning, so sel reads 0 in IDLE.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clr       = 1'b1;
        case (state)
            IDLE: begin
                if (en) begin
                    load      = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                clr = !en;
                if (!en)            state_nxt = IDLE;
                else if (frame_end) load      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign run  = (state == SCAN);
    assign busy = (state == SCAN);
    assign sel  = slot;

    always_comb begin
        assembled = shreg;
        if (slot_end) assembled[slot] = line_in;
    end

    always_ff @(posedge clk) begin
        if (rst) shreg <= '0;
        else     shreg <= assembled;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_hold      <= '0;
            q           <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_end;
            if (frame_end) q      <= assembled;
            if (load)      d_hold <= d_in;
        end
    end

`ifdef TDM_SCAN_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)            frame_cnt <= '0;
        else if (frame_end) frame_cnt <= frame_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_tdm_scan_ctrl.sv
// tb/tb_tdm_scan_ctrl.sv - directed self-checking bench for tdm_scan_ctrl (DWELL 1 and 3)
module tb_tdm_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       en1, en3;
    logic [3:0] d_in1, d_in3;
    logic       line1, line3;
    logic [3:0] d_hold1, d_hold3, q1, q3;
    logic [1:0] sel1, sel3;
    logic       fv1, fv3, busy1, busy3;
`ifdef TDM_SCAN_FRAME_CNT_EN
    logic [7:0] fcnt1, fcnt3;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign line1 = d_hold1[sel1];
    assign line3 = d_hold3[sel3];

    tdm_scan_ctrl #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .d_in(d_in1), .line_in(line1),
        .d_hold(d_hold1), .sel(sel1), .q(q1), .frame_valid(fv1), .busy(busy1)
`ifdef TDM_SCAN_FRAME_CNT_EN
        , .frame_cnt(fcnt1)
`endif
    );

    tdm_scan_ctrl #(.DWELL(3)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .d_in(d_in3), .line_in(line3),
        .d_hold(d_hold3), .sel(sel3), .q(q3), .frame_valid(fv3), .busy(busy3)
`ifdef TDM_SCAN_FRAME_CNT_EN
        , .frame_cnt(fcnt3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en1 = 1'b0; en3 = 1'b0; d_in1 = 4'h0; d_in3 = 4'h0;
        tick(); tick();
        chk("rst_q",      {4'h0, q1},      8'h00);
        chk("rst_sel",    {6'h0, sel1},    8'h00);
        chk("rst_d_hold", {4'h0, d_hold1}, 8'h00);
        chk("rst_fv",     {7'h0, fv1},     8'h00);
        chk("rst_busy",   {7'h0, busy1},   8'h00);

        // Loopback DWELL=1 and back-to-back frames
        rst = 1'b0; en1 = 1'b1; d_in1 = 4'b0110;
        tick();
        chk("e0_sel",    {6'h0, sel1},    8'h00);
        chk("e0_d_hold", {4'h0, d_hold1}, 8'h06);
        chk("e0_busy",   {7'h0, busy1},   8'h01);
        d_in1 = 4'b1001;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("d1_sel", {6'h0, sel1}, 8'(k));
            chk("d1_fv",  {7'h0, fv1},  8'h00);
        end
        tick();
        chk("f1_q",      {4'h0, q1},      8'h06);
        chk("f1_fv",     {7'h0, fv1},     8'h01);
        chk("f1_sel",    {6'h0, sel1},    8'h00);
        chk("f1_reload", {4'h0, d_hold1}, 8'h09);
        tick();
        chk("f1_fv_off", {7'h0, fv1},     8'h00);
        tick(); tick(); tick();
        chk("f2_q",  {4'h0, q1},  8'h09);
        chk("f2_fv", {7'h0, fv1}, 8'h01);

        // Mid-frame drop on DWELL=1
        en1 = 1'b0;
        tick();
        chk("drop1_busy", {7'h0, busy1}, 8'h00);
        chk("drop1_sel",  {6'h0, sel1},  8'h00);
        chk("drop1_q",    {4'h0, q1},    8'h09);
        chk("drop1_fv",   {7'h0, fv1},   8'h00);

        // Reset mid-frame, then a clean frame
        en1 = 1'b1; d_in1 = 4'b1100;
        tick(); tick(); tick();
        chk("pre_rst_sel", {6'h0, sel1}, 8'h02);
        rst = 1'b1;
        tick();
        chk("mrst_q",      {4'h0, q1},      8'h00);
        chk("mrst_sel",    {6'h0, sel1},    8'h00);
        chk("mrst_d_hold", {4'h0, d_hold1}, 8'h00);
        chk("mrst_busy",   {7'h0, busy1},   8'h00);
        rst = 1'b0;
        tick();
        chk("post_rst_d_hold", {4'h0, d_hold1}, 8'h0c);
        tick(); tick(); tick(); tick();
        chk("post_rst_q",  {4'h0, q1},  8'h0c);
        chk("post_rst_fv", {7'h0, fv1}, 8'h01);
        en1 = 1'b0;
        tick(); tick();

        // DWELL=3: each sel held three cycles
        en3 = 1'b1; d_in3 = 4'b1010;
        tick();
        chk("d3_e0_d_hold", {4'h0, d_hold3}, 8'h0a);
        d_in3 = 4'b0110;
        for (int k = 1; k < 12; k++) begin
            tick();
            chk("d3_sel", {6'h0, sel3}, 8'(k / 3));
            chk("d3_fv",  {7'h0, fv3},  8'h00);
        end
        tick();
        chk("d3_f1_q",  {4'h0, q3},  8'h0a);
        chk("d3_f1_fv", {7'h0, fv3}, 8'h01);
        d_in3 = 4'b1111;
        for (int k = 1; k < 12; k++) tick();
        tick();
        chk("d3_f2_q",  {4'h0, q3},  8'h06);
        chk("d3_f2_fv", {7'h0, fv3}, 8'h01);
        for (int k = 1; k < 10; k++) tick();
        chk("d3_slot3_sel", {6'h0, sel3}, 8'h03);
        en3 = 1'b0;
        tick();
        chk("drop3_sel",  {6'h0, sel3},  8'h00);
        chk("drop3_busy", {7'h0, busy3}, 8'h00);
        chk("drop3_q",    {4'h0, q3},    8'h06);
        for (int k = 0; k < 4; k++) begin
            chk("drop3_fv", {7'h0, fv3}, 8'h00);
            tick();
        end

`ifdef TDM_SCAN_FRAME_CNT_EN
        rst = 1'b1;
        tick();
        chk("fcnt_rst", fcnt1, 8'h00);
        rst = 1'b0; en1 = 1'b1; d_in1 = 4'b0101;
        tick();
        for (int k = 0; k < 257 * 4; k++) tick();
        chk("fcnt_wrap", fcnt1, 8'h01);
        en1 = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
